// File: rtl/att_pkg.sv
// att_pkg: shared state encoding and default sizing for the attenuator serial receiver.
package att_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int ATT_NBITS = 6;
  localparam int ATT_TIMEOUT = 64;
endpackage

// File: rtl/att_serial_rx_if.sv
// att_serial_rx_if: attenuator serial bus inputs plus decoded setting/status outputs.
interface att_serial_rx_if #(parameter int NBITS = 6);
  logic att_le;
  logic att_clk;
  logic att_data;
  logic [NBITS-1:0] setting;
  logic valid;
  logic err;
  logic busy;
  modport master (output att_le, att_clk, att_data, input setting, valid, err, busy);
  modport slave (input att_le, att_clk, att_data, output setting, valid, err, busy);
endinterface

// File: rtl/att_sync2.sv
// att_sync2: single-bit two-flop synchronizer with synchronous clear.
module att_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/att_serial_rx.sv
// att_serial_rx: receives MSB-first attenuator words framed by att_le; ATT_RX_SYNC_EN adds input synchronizers.
module att_serial_rx
  import att_pkg::*;
#(
  parameter int NBITS = ATT_NBITS,
  parameter int TIMEOUT = ATT_TIMEOUT
) (
  input logic clk,
  input logic rst,
  att_serial_rx_if.slave bus
);
  localparam int CW = $clog2(NBITS + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic le_i, ck_i, d_i;
`ifdef ATT_RX_SYNC_EN
  att_sync2 u_le (.clk(clk), .rst(rst), .d(bus.att_le), .q(le_i));
  att_sync2 u_ck (.clk(clk), .rst(rst), .d(bus.att_clk), .q(ck_i));
  att_sync2 u_d (.clk(clk), .rst(rst), .d(bus.att_data), .q(d_i));
`else
  assign le_i = bus.att_le;
  assign ck_i = bus.att_clk;
  assign d_i = bus.att_data;
`endif
  logic le_q, le_p, ck_q, ck_p, d_q, le_rise, ck_rise;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [NBITS-1:0] sh, sh_n, setting, setting_n;
  logic valid, valid_n, err, err_n;
  assign le_rise = le_q & ~le_p;
  assign ck_rise = ck_q & ~ck_p;
  always_ff @(posedge clk)
    if (rst) begin
      {le_q, le_p, ck_q, ck_p, d_q} <= '0;
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      sh <= '0;
      setting <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      {le_q, le_p, ck_q, ck_p, d_q} <= {le_i, le_q, ck_i, ck_q, d_i};
      state <= state_n;
      cnt <= cnt_n;
      timer <= timer_n;
      sh <= sh_n;
      setting <= setting_n;
      valid <= valid_n;
      err <= err_n;
    end
  // A bit clock in the same cycle as the latch is shifted before the count is judged.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    timer_n = timer;
    sh_n = sh;
    setting_n = setting;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (ck_rise) begin
      sh_n = NBITS'({sh, d_q});
      cnt_n = state == IDLE ? CW'(1) : cnt == CW'(NBITS + 1) ? cnt : cnt + 1'b1;
      timer_n = '0;
      state_n = SHIFT;
    end else if (state == SHIFT) begin
      timer_n = timer + 1'b1;
      if (timer_n == TW'(TIMEOUT)) begin
        err_n = 1'b1;
        state_n = IDLE;
        cnt_n = '0;
        timer_n = '0;
      end
    end
    if (le_rise) begin
      valid_n = state_n == SHIFT && cnt_n == CW'(NBITS);
      err_n = !valid_n;
      setting_n = valid_n ? sh_n : setting;
      state_n = IDLE;
      cnt_n = '0;
      timer_n = '0;
    end
  end
  assign bus.setting = setting;
  assign bus.valid = valid;
  assign bus.err = err;
  assign bus.busy = state == SHIFT;
endmodule

// File: tb/tb_att_serial_rx.sv
// tb_att_serial_rx: directed frames against hand-computed settings, pulse counts and latencies.
module tb_att_serial_rx;
`ifdef ATT_RX_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 2 + EXTRA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  int vcnt = 0, ecnt = 0, vcyc = 0, ecyc = 0, both = 0, wide = 0, le_cyc = 0, rise_cyc = 0;
  logic [5:0] vset = '0, vset_prev = '0;
  logic pv = 1'b0, pe = 1'b0;
  att_serial_rx_if bus ();
  att_serial_rx dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.valid) begin
      vcnt++;
      vcyc = cyc;
      vset_prev = vset;
      vset = bus.setting;
    end
    if (bus.err) begin
      ecnt++;
      ecyc = cyc;
    end
    if (bus.valid && bus.err) both++;
    if ((bus.valid && pv) || (bus.err && pe)) wide++;
    pv = bus.valid;
    pe = bus.err;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.att_data = v[i];
      bus.att_clk = 1'b0;
      tick();
      bus.att_clk = 1'b1;
      rise_cyc = cyc;
      tick();
    end
    bus.att_clk = 1'b0;
  endtask
  task automatic pulse_le();
    bus.att_le = 1'b1;
    le_cyc = cyc;
    tick();
    bus.att_le = 1'b0;
  endtask
  task automatic test_reset();
    bus.att_le = 1'b0;
    bus.att_clk = 1'b0;
    bus.att_data = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.setting !== 6'h00) begin errors++; $display("FAIL reset_setting got %0h exp 0", bus.setting); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_good_frame();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_bits(8'h2D, 6);
    pulse_le();
    repeat (8) tick();
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL good_valid_count got %0d exp 1", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL good_err_count got %0d exp 0", ecnt - e0); end
    checks++; if (bus.setting !== 6'h2D) begin errors++; $display("FAIL good_setting got %0h exp 2d", bus.setting); end
    checks++; if (vcyc - le_cyc !== LAT) begin errors++; $display("FAIL good_latency got %0d exp %0d", vcyc - le_cyc, LAT); end
  endtask
  task automatic test_bad_count(input int n);
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_bits(8'h55, n);
    pulse_le();
    repeat (8) tick();
    checks++; if (ecnt - e0 !== 1) begin errors++; $display("FAIL bad%0d_err_count got %0d exp 1", n, ecnt - e0); end
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL bad%0d_valid_count got %0d exp 0", n, vcnt - v0); end
    checks++; if (bus.setting !== 6'h2D) begin errors++; $display("FAIL bad%0d_setting got %0h exp 2d", n, bus.setting); end
    checks++; if (ecyc - le_cyc !== LAT) begin errors++; $display("FAIL bad%0d_err_latency got %0d exp %0d", n, ecyc - le_cyc, LAT); end
  endtask
  task automatic test_timeout();
    int v0, e0, c0, n;
    e0 = ecnt;
    send_bits(8'h05, 3);
    c0 = rise_cyc;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got %b exp 1", bus.busy); end
    n = 0;
    while (ecnt == e0 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (ecyc - c0 !== 66 + EXTRA || ecnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_cycle got %0d exp %0d (count %0d)", ecyc - c0, 66 + EXTRA, ecnt - e0); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got %b exp 0", bus.busy); end
    v0 = vcnt;
    send_bits(8'h15, 6);
    pulse_le();
    repeat (8) tick();
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL timeout_next_valid got %0d exp 1", vcnt - v0); end
    checks++; if (bus.setting !== 6'h15) begin errors++; $display("FAIL timeout_next_setting got %0h exp 15", bus.setting); end
  endtask
  task automatic test_rst_mid_frame();
    int v0, e0;
    send_bits(8'h07, 3);
    rst = 1'b1;
    tick();
    checks++; if (bus.setting !== 6'h00) begin errors++; $display("FAIL rstmid_setting got %0h exp 0", bus.setting); end
    checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b%b exp 000", bus.busy, bus.valid, bus.err); end
    rst = 1'b0;
    v0 = vcnt; e0 = ecnt;
    repeat (80) tick();
    checks++; if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin errors++; $display("FAIL rstmid_no_pulse got v%0d e%0d exp v0 e0", vcnt - v0, ecnt - e0); end
    send_bits(8'h3F, 6);
    pulse_le();
    repeat (8) tick();
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL rstmid_next_valid got %0d exp 1", vcnt - v0); end
    checks++; if (bus.setting !== 6'h3F) begin errors++; $display("FAIL rstmid_next_setting got %0h exp 3f", bus.setting); end
  endtask
  task automatic test_back_to_back();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_bits(8'h01, 6);
    pulse_le();
    tick();
    send_bits(8'h3E, 6);
    pulse_le();
    repeat (8) tick();
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d exp 2", vcnt - v0); end
    checks++; if (ecnt - e0 !== 0) begin errors++; $display("FAIL b2b_err_count got %0d exp 0", ecnt - e0); end
    checks++; if (vset_prev !== 6'h01) begin errors++; $display("FAIL b2b_first_setting got %0h exp 01", vset_prev); end
    checks++; if (vset !== 6'h3E || bus.setting !== 6'h3E) begin errors++; $display("FAIL b2b_second_setting got %0h/%0h exp 3e", vset, bus.setting); end
    checks++; if (vcyc - le_cyc !== LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", vcyc - le_cyc, LAT); end
  endtask
  task automatic test_le_idle();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    bus.att_le = 1'b1;
    repeat (4) tick();
    bus.att_le = 1'b0;
    repeat (6) tick();
    checks++; if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin errors++; $display("FAIL le_idle_pulses got e%0d v%0d exp e1 v0", ecnt - e0, vcnt - v0); end
    checks++; if (bus.setting !== 6'h3E) begin errors++; $display("FAIL le_idle_setting got %0h exp 3e", bus.setting); end
  endtask
  task automatic test_pulse_shape();
    checks++; if (both !== 0) begin errors++; $display("FAIL shape_overlap got %0d exp 0", both); end
    checks++; if (wide !== 0) begin errors++; $display("FAIL shape_width got %0d exp 0", wide); end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_count(5);
    test_bad_count(7);
    test_timeout();
    test_rst_mid_frame();
    test_back_to_back();
    test_le_idle();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
